// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// plus a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  output logic                   pc_en,
  output logic [1:0]             pc_source,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   instr_done,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [3:0]             state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_INIT      = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH     = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE    = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd6;
  localparam logic [STATE_W-1:0] S_R_EXEC    = 4'd7;
  localparam logic [STATE_W-1:0] S_R_WB      = 4'd8;
  localparam logic [STATE_W-1:0] S_BRANCH    = 4'd9;
  localparam logic [STATE_W-1:0] S_JUMP      = 4'd10;
  localparam logic [STATE_W-1:0] S_ADDI_EXEC = 4'd11;
  localparam logic [STATE_W-1:0] S_ADDI_WB   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [STATE_W-1:0]     state_q;
  logic [STATE_W-1:0]     state_d;
  logic                   opcode_known_c;
  logic                   illegal_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Opcodes this control unit knows how to sequence
  always_comb begin
    opcode_known_c = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_known_c = 1'b1;
      default:                                       opcode_known_c = 1'b0;
    endcase
  end

  // Next-state logic; unused codes recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore output decode; BRANCH's pc_en is the only input-dependent term
  always_comb begin
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          count_q <= '0;
    else if (instr_done) count_q <= count_q + COUNT_WIDTH'(1);
  end

  // Sticky flag, set when DECODE sees an unsupported opcode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                       illegal_q <= 1'b0;
    else if ((state_q == S_DECODE) && !opcode_known_c) illegal_q <= 1'b1;
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level model predicts the state walk,
// control strobes, retired count (32-bit and 2-bit instances) and the illegal flag.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctl_t;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;

  logic        pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  logic        u2_pc_en, u2_i_or_d, u2_mem_read, u2_mem_write, u2_ir_write, u2_reg_write;
  logic        u2_reg_dst, u2_mem_to_reg, u2_alu_src_a, u2_instr_done, u2_illegal;
  logic [1:0]  u2_pc_source, u2_alu_src_b, u2_alu_op;
  logic [1:0]  u2_instr_count;
  logic [3:0]  u2_state;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.COUNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_en(u2_pc_en), .pc_source(u2_pc_source), .i_or_d(u2_i_or_d), .mem_read(u2_mem_read),
    .mem_write(u2_mem_write), .ir_write(u2_ir_write), .reg_write(u2_reg_write),
    .reg_dst(u2_reg_dst), .mem_to_reg(u2_mem_to_reg), .alu_src_a(u2_alu_src_a),
    .alu_src_b(u2_alu_src_b), .alu_op(u2_alu_op), .instr_done(u2_instr_done),
    .illegal(u2_illegal), .instr_count(u2_instr_count), .state(u2_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ctl_t act, act2;
  always_comb begin
    act  = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done};
    act2 = {u2_pc_en, u2_pc_source, u2_i_or_d, u2_mem_read, u2_mem_write, u2_ir_write,
            u2_reg_write, u2_reg_dst, u2_mem_to_reg, u2_alu_src_a, u2_alu_src_b, u2_alu_op,
            u2_instr_done};
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the instruction in flight and the states it still has to visit
  int          seq[$];
  logic [5:0]  cur_op;
  bit          cur_is_instr;
  int unsigned m_count;
  bit          m_illegal;
  int          dir_ops[$] = '{'h23, 'h04, 'h04, 'h00, 'h2B, 'h08, 'h02, 'h3F,
                              'h23, 'h02, 'h02, 'h02, 'h02, 'h02};

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h08) ||
           (op == 6'h23) || (op == 6'h2B);
  endfunction

  // State walk of one instruction, starting at FETCH
  function automatic void load_seq(input logic [5:0] op);
    seq = '{1, 2};
    case (op)
      6'h23:   begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
      6'h2B:   begin seq.push_back(3); seq.push_back(6); end
      6'h00:   begin seq.push_back(7); seq.push_back(8); end
      6'h08:   begin seq.push_back(11); seq.push_back(12); end
      6'h04:   seq.push_back(9);
      6'h02:   seq.push_back(10);
      default: ;
    endcase
  endfunction

  // Control word the datapath needs in each step
  function automatic ctl_t exp_ctl(input int st, input logic z);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_en = 1; end
      2:  c.alu_src_b = 2'b11;
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1; c.i_or_d = 1; end
      5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      6:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = 1; end
      7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_en = z;
                c.instr_done = 1; end
      10: begin c.pc_source = 2'b10; c.pc_en = 1; c.instr_done = 1; end
      11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1; c.instr_done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal_ops [6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    if (dir_ops.size() > 0) return 6'(dir_ops.pop_front());
    if ($urandom_range(0, 9) < 8) return legal_ops[$urandom_range(0, 5)];
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic model_reset();
    seq          = '{0};
    cur_is_instr = 1'b0;
    m_count      = 0;
    m_illegal    = 1'b0;
  endtask

  task automatic check_all();
    logic [1:0] c2;
    c2 = m_count[1:0];
    check("state", 32'(state), 32'(seq[0]));
    check("ctl", 32'(act), 32'(exp_ctl(seq[0], zero)));
    check("count", instr_count, m_count);
    check("illegal", 32'(illegal), 32'(m_illegal));
    check("state_w2", 32'(u2_state), 32'(seq[0]));
    check("ctl_w2", 32'(act2), 32'(exp_ctl(seq[0], zero)));
    check("count_w2", 32'(u2_instr_count), 32'(c2));
  endtask

  initial begin
    bit new_instr;
    int n_rst;
    n_rst  = 0;
    reset  = 1'b0;
    opcode = 6'h00;
    zero   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      check_all();
      @(posedge clock);
      // advance the model by one edge
      void'(seq.pop_front());
      new_instr = 1'b0;
      if (seq.size() == 0) begin
        if (cur_is_instr) begin
          if (is_legal(cur_op)) m_count++;
          else                  m_illegal = 1'b1;
        end
        cur_op       = pick_op();
        cur_is_instr = 1'b1;
        load_seq(cur_op);
        new_instr    = 1'b1;
      end
      #1;
      if (seq[0] == 4 && n_rst < 3 && $urandom_range(0, 2) == 0) begin
        n_rst++;
        reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_count_w2", 32'(u2_instr_count), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
      end else begin
        if (new_instr) opcode = cur_op;
        zero = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
